mult_ctrl: RTL and testbench
============================

// Module: mult_ctrl
// PURPOSE
//  Sequencer for the add-shift signed multiplier datapath: the X/A/B shift-register chain plus the 9-bit adder/subtractor.
//  Issues clear, load, add/subtract and shift strobes for N_BITS iterations per Run.
//  Sits between the debounced switch/button inputs and the datapath registers.
// PARAMETERS
//  N_BITS   8   multiplier width = iteration count; power of 2, >= 2
// PORTS
//  Clk            in   1       clock
//  Reset          in   1       synchronous, active-high reset
//  Run            in   1       start request, level (debounced); one multiply per assertion
//  ClearA_LoadB   in   1       level; in IDLE clears X/A and loads B from switches
//  M              in   1       current B LSB (B Shift_Out); selects add/skip
//  Clr_XA         out  1       synchronous clear of X and A
//  Ld_B           out  1       parallel load of B
//  Ld_XA          out  1       load adder result into X and A
//  Fn             out  1       0 = A+S, 1 = A-S (adder function)
//  Shift_En       out  1       shift X->A->B chain one bit right
//  Busy           out  1       high from CLR through last SHIFT
//  Done           out  1       high in HOLD
//  Count          out  $clog2(N_BITS)  current iteration index (debug)
// BEHAVIOUR
//  - Reset: state=IDLE, Count=0; every output 0 the cycle after Reset is sampled, including mid-run.
//  - States: IDLE, CLR, ADD, SHIFT, HOLD. Outputs decode from state (Moore); Ld_XA also depends on M.
//  - IDLE:
//    - Run=1 -> CLR.
//    - Else ClearA_LoadB=1 -> Ld_B=1 and Clr_XA=1 combinationally that cycle; stay IDLE.
//    - Run has priority: with both high, Ld_B stays 0.
//  - CLR: Clr_XA=1, Busy=1, Count<=0 -> ADD.
//  - ADD: Busy=1; Ld_XA=M; Fn=(Count==N_BITS-1) (last iteration subtracts); Fn=0 otherwise -> SHIFT.
//  - SHIFT: Shift_En=1, Busy=1.
//    - Count==N_BITS-1 -> HOLD, Count<=0.
//    - Else Count<=Count+1 -> ADD.
//  - HOLD: Done=1; stay while Run=1 (no auto-restart); Run=0 -> IDLE.
//  - Latency: Run sampled in IDLE at edge k -> CLR during cycle k+1; Busy for exactly 1+2*N_BITS cycles; Done from cycle k+2+2*N_BITS.
//  - Strobes are mutually exclusive except the IDLE pair Ld_B+Clr_XA. Shift_En and Ld_XA are never high together.
//  - ClearA_LoadB is ignored outside IDLE. Run deassertion mid-run is ignored; the run completes.
//  - Count wraps only via the explicit reset to 0; it never increments outside SHIFT.
// STRUCTURE
//  - mult_ctrl_pkg: state_t enum {IDLE,CLR,ADD,SHIFT,HOLD}; localparam CNT_W=$clog2(N_BITS).
//  - One sub-module: iter_counter (sync clear, enable, terminal-count flag at N_BITS-1). All else lives in mult_ctrl.
//  - Two always blocks: state/count register (always_ff) and next-state/output decode (always_comb, defaults 0).
// TESTING
//  1 Reset held 3 cycles, release, inputs 0 -> all outputs 0, Count=0, IDLE for 10 cycles.
//  2 IDLE, ClearA_LoadB=1 one cycle -> Ld_B=1, Clr_XA=1 that cycle only; Busy stays 0.
//  3 Run=1, M sequence 1,0,1,1,0,0,0,1 per ADD:
//    - Clr_XA once.
//    - Ld_XA in ADD of iterations 0,2,3,7.
//    - Fn=1 only in iteration 7's ADD.
//    - 8 Shift_En pulses; Busy 17 cycles; then Done=1.
//  4 Run held after Done 20 cycles -> stays HOLD, no strobes; Run=0 -> IDLE next cycle; Run=1 again -> new CLR.
//  5 Reset during iteration 3 ADD -> next cycle IDLE, Count=0, Busy=0, all strobes 0.
//  6 Run and ClearA_LoadB both 1 in IDLE -> CLR entered, Ld_B never asserted; ClearA_LoadB pulsed during SHIFT -> no Ld_B.
//  + Scoreboard: with reg_8/reg_1 and adder models, check 8'h07*8'hFE=16'hFFF2 and 8'h80*8'h80=16'h4000 in A:B at Done.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg
//   Shared types and sizing helpers for the add-shift multiplier sequencer.
//   state_t    : sequencer states (IDLE, CLR, ADD, SHIFT, HOLD)
//   N_BITS_DEF : default multiplier width
//   CNT_W      : iteration counter width for the default width
//   cnt_w()    : iteration counter width for an arbitrary width
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int N_BITS_DEF = 8;
  localparam int CNT_W      = $clog2(N_BITS_DEF);

  // Counter width for n iterations; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_ctrl_if.sv
// mult_ctrl_if
//   Bundle between the multiplier sequencer and the rest of the datapath.
//   Inputs to the sequencer : Run, ClearA_LoadB, M (B shift-out bit)
//   Strobes from sequencer  : Clr_XA, Ld_B, Ld_XA, Fn, Shift_En
//   Status from sequencer   : Busy, Done, Count
//   master : the sequencer side; slave : the datapath / switch side.
interface mult_ctrl_if
  import mult_ctrl_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
);

  logic                      Run;
  logic                      ClearA_LoadB;
  logic                      M;
  logic                      Clr_XA;
  logic                      Ld_B;
  logic                      Ld_XA;
  logic                      Fn;
  logic                      Shift_En;
  logic                      Busy;
  logic                      Done;
  logic [cnt_w(N_BITS)-1:0]  Count;

  modport master (
    input  Run, ClearA_LoadB, M,
    output Clr_XA, Ld_B, Ld_XA, Fn, Shift_En, Busy, Done, Count
  );

  modport slave (
    output Run, ClearA_LoadB, M,
    input  Clr_XA, Ld_B, Ld_XA, Fn, Shift_En, Busy, Done, Count
  );

endinterface

// File: rtl/mult_ctrl_iter_counter.sv
// iter_counter
//   Iteration index for the multiplier sequencer.
//   Clk      : clock
//   i_clr    : synchronous clear (wins over enable)
//   i_en     : count up by one
//   o_count  : current iteration index
//   o_tc     : high while the index equals N_BITS-1 (last iteration)
module iter_counter
  import mult_ctrl_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic                     Clk,
  input  logic                     i_clr,
  input  logic                     i_en,
  output logic [cnt_w(N_BITS)-1:0] o_count,
  output logic                     o_tc
);

  localparam int CW = cnt_w(N_BITS);

  logic [CW-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (i_clr)
      r_count <= '0;
    else if (i_en)
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == CW'(N_BITS - 1));

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl
//   Sequencer for the add-shift signed multiplier: drives the X/A/B shift
//   chain and the 9-bit adder/subtractor for N_BITS add/shift iterations
//   per Run request.
//   Clk    : clock
//   Reset  : synchronous, active-high reset
//   bus    : mult_ctrl_if master modport
//            in : Run, ClearA_LoadB, M
//            out: Clr_XA, Ld_B, Ld_XA, Fn, Shift_En, Busy, Done, Count
module mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  mult_ctrl_if.master bus
);

  localparam int CW = cnt_w(N_BITS);

  state_t          r_state;
  state_t          w_next;
  logic            w_cnt_clr;
  logic            w_cnt_en;
  logic            w_tc;
  logic [CW-1:0]   w_count;

  logic            w_clr_xa;
  logic            w_ld_b;
  logic            w_ld_xa;
  logic            w_fn;
  logic            w_shift_en;
  logic            w_busy;
  logic            w_done;

  // Reset also clears the iteration index so Count reads 0 right after it.
  iter_counter #(.N_BITS(N_BITS)) u_iter_counter (
    .Clk     (Clk),
    .i_clr   (Reset | w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  always_ff @(posedge Clk) begin
    if (Reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_cnt_en   = 1'b0;
    w_clr_xa   = 1'b0;
    w_ld_b     = 1'b0;
    w_ld_xa    = 1'b0;
    w_fn       = 1'b0;
    w_shift_en = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;

    case (r_state)
      IDLE: begin
        // Run wins over the load request so a load never overlaps a start.
        if (bus.Run) begin
          w_next = CLR;
        end else if (bus.ClearA_LoadB) begin
          w_ld_b   = 1'b1;
          w_clr_xa = 1'b1;
        end
      end
      CLR: begin
        w_clr_xa  = 1'b1;
        w_busy    = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = ADD;
      end
      ADD: begin
        w_busy  = 1'b1;
        w_ld_xa = bus.M;
        // The multiplier MSB carries negative weight, so the last
        // partial product is subtracted.
        w_fn    = w_tc;
        w_next  = SHIFT;
      end
      SHIFT: begin
        w_busy     = 1'b1;
        w_shift_en = 1'b1;
        if (w_tc) begin
          w_cnt_clr = 1'b1;
          w_next    = HOLD;
        end else begin
          w_cnt_en  = 1'b1;
          w_next    = ADD;
        end
      end
      HOLD: begin
        w_done = 1'b1;
        // Wait for Run to drop so one level assertion gives one multiply.
        if (!bus.Run)
          w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign bus.Clr_XA   = w_clr_xa;
  assign bus.Ld_B     = w_ld_b;
  assign bus.Ld_XA    = w_ld_xa;
  assign bus.Fn       = w_fn;
  assign bus.Shift_En = w_shift_en;
  assign bus.Busy     = w_busy;
  assign bus.Done     = w_done;
  assign bus.Count    = w_count;

endmodule

// File: tb/tb_mult_ctrl.sv
module tb_mult_ctrl;
  import mult_ctrl_pkg::*;

  localparam int N = 8;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  sw    = 8'h00;

  // Datapath model: X/A/B chain plus 9-bit adder/subtractor.
  logic        mX = 1'b0;
  logic [7:0]  mA = 8'h00;
  logic [7:0]  mB = 8'h00;
  logic        s_clr = 1'b0, s_ldb = 1'b0, s_ldxa = 1'b0, s_fn = 1'b0, s_sh = 1'b0;

  logic [15:0] sbq[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  mult_ctrl_if #(.N_BITS(N)) bus();

  mult_ctrl #(.N_BITS(N)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  assign bus.M = mB[0];

  wire [9:0] outs = {bus.Clr_XA, bus.Ld_B, bus.Ld_XA, bus.Fn, bus.Shift_En,
                     bus.Busy, bus.Done, bus.Count};

  // Strobes are captured mid-cycle and applied at the next rising edge.
  always @(negedge Clk) begin
    s_clr  <= bus.Clr_XA;
    s_ldb  <= bus.Ld_B;
    s_ldxa <= bus.Ld_XA;
    s_fn   <= bus.Fn;
    s_sh   <= bus.Shift_En;
  end

  wire [8:0] a9   = {mA[7], mA};
  wire [8:0] s9   = {sw[7], sw};
  wire [8:0] sum9 = s_fn ? (a9 - s9) : (a9 + s9);

  always @(posedge Clk) begin
    if (s_clr) begin
      mX <= 1'b0;
      mA <= 8'h00;
    end
    if (s_ldb)
      mB <= sw;
    if (s_ldxa) begin
      mX <= sum9[8];
      mA <= sum9[7:0];
    end
    if (s_sh) begin
      mA <= {mX, mA[7:1]};
      mB <= {mA[0], mB[7:1]};
    end
  end

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk_cnt++;
      if (outs !== 10'd0)
        $display("FAIL reset_idle cyc%0d: outputs got %b expected %b", i, outs, 10'd0);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_load;
    @(posedge Clk); #1;
    sw = 8'h8D;
    bus.ClearA_LoadB = 1'b1;
    @(negedge Clk);
    chk_cnt++;
    if ({bus.Ld_B, bus.Clr_XA, bus.Busy} !== 3'b110)
      $display("FAIL load_pulse: {Ld_B,Clr_XA,Busy} got %b expected 110", {bus.Ld_B, bus.Clr_XA, bus.Busy});
    else
      pass_cnt++;
    @(posedge Clk); #1;
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    chk_cnt++;
    if ({bus.Ld_B, bus.Clr_XA, bus.Busy} !== 3'b000)
      $display("FAIL load_release: {Ld_B,Clr_XA,Busy} got %b expected 000", {bus.Ld_B, bus.Clr_XA, bus.Busy});
    else
      pass_cnt++;
  endtask

  task automatic test_run_seq;
    int busy_n = 0, clr_n = 0, sh_n = 0, both_n = 0, fn_n = 0;
    int first_busy = -1, done_idx = -1;
    logic [7:0] ldm = 8'h00, fnm = 8'h00;
    logic signed [15:0] e;
    logic [15:0] got;
    @(posedge Clk); #1;
    sw = 8'h03;
    bus.Run = 1'b1;
    e = $signed(sw) * $signed(mB);
    sbq.push_back(e);
    for (int c = 0; c < 60; c++) begin
      @(negedge Clk);
      if (bus.Busy) begin
        busy_n++;
        if (first_busy < 0) first_busy = c;
      end
      clr_n  += int'(bus.Clr_XA);
      sh_n   += int'(bus.Shift_En);
      fn_n   += int'(bus.Fn);
      both_n += int'(bus.Ld_XA && bus.Shift_En);
      if (bus.Busy && !bus.Clr_XA && !bus.Shift_En) begin
        if (bus.Ld_XA) ldm[bus.Count] = 1'b1;
        if (bus.Fn)    fnm[bus.Count] = 1'b1;
      end
      if (bus.Done) begin
        done_idx = c;
        break;
      end
      @(posedge Clk); #1;
    end
    chk_cnt++;
    if (done_idx !== 18) $display("FAIL run_done_latency: got %0d expected 18", done_idx); else pass_cnt++;
    chk_cnt++;
    if (first_busy !== 1) $display("FAIL run_busy_start: got %0d expected 1", first_busy); else pass_cnt++;
    chk_cnt++;
    if (busy_n !== 17) $display("FAIL run_busy_len: got %0d expected 17", busy_n); else pass_cnt++;
    chk_cnt++;
    if (clr_n !== 1) $display("FAIL run_clr_count: got %0d expected 1", clr_n); else pass_cnt++;
    chk_cnt++;
    if (ldm !== 8'h8D) $display("FAIL run_ldxa_iters: got %h expected 8d", ldm); else pass_cnt++;
    chk_cnt++;
    if (fnm !== 8'h80) $display("FAIL run_fn_iters: got %h expected 80", fnm); else pass_cnt++;
    chk_cnt++;
    if (fn_n !== 1) $display("FAIL run_fn_total: got %0d expected 1", fn_n); else pass_cnt++;
    chk_cnt++;
    if (sh_n !== 8) $display("FAIL run_shift_count: got %0d expected 8", sh_n); else pass_cnt++;
    chk_cnt++;
    if (both_n !== 0) $display("FAIL run_ldxa_shift_overlap: got %0d expected 0", both_n); else pass_cnt++;
    chk_cnt++;
    if (sbq.size() == 0) begin
      $display("FAIL run_product: scoreboard empty, got %h", {mA, mB});
    end else begin
      got = sbq.pop_front();
      if ({mA, mB} !== got) $display("FAIL run_product: got %h expected %h", {mA, mB}, got);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    int bad = 0;
    logic signed [15:0] e;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      if (!bus.Done || bus.Clr_XA || bus.Ld_B || bus.Ld_XA || bus.Shift_En || bus.Busy)
        bad++;
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL hold_stable: bad cycles got %0d expected 0", bad); else pass_cnt++;
    @(posedge Clk); #1;
    bus.Run = 1'b0;
    @(negedge Clk);
    chk_cnt++;
    if (bus.Done !== 1'b1) $display("FAIL hold_before_exit: Done got %b expected 1", bus.Done); else pass_cnt++;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk_cnt++;
    if ({bus.Done, bus.Busy} !== 2'b00) $display("FAIL hold_exit_idle: {Done,Busy} got %b expected 00", {bus.Done, bus.Busy}); else pass_cnt++;
    @(posedge Clk); #1;
    bus.Run = 1'b1;
    e = $signed(sw) * $signed(mB);
    sbq.push_back(e);
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk_cnt++;
    if ({bus.Clr_XA, bus.Busy} !== 2'b11) $display("FAIL restart_clr: {Clr_XA,Busy} got %b expected 11", {bus.Clr_XA, bus.Busy}); else pass_cnt++;
  endtask

  task automatic test_reset_midrun;
    bit found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      if (bus.Busy && !bus.Clr_XA && !bus.Shift_En && bus.Count == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (found !== 1'b1) $display("FAIL midrun_find_add3: got %b expected 1", found); else pass_cnt++;
    Reset   = 1'b1;
    bus.Run = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk_cnt++;
    if (outs !== 10'd0) $display("FAIL midrun_reset: outputs got %b expected %b", outs, 10'd0); else pass_cnt++;
    sbq.delete();
  endtask

  task automatic test_priority;
    int ldb_n = 0, sh_n = 0;
    bit pulsed = 1'b0, done_seen = 1'b0;
    logic signed [15:0] e;
    logic [15:0] got;
    @(posedge Clk); #1;
    sw = 8'hB5;
    bus.ClearA_LoadB = 1'b1;
    @(posedge Clk); #1;
    sw = 8'h6C;
    bus.Run = 1'b1;
    e = $signed(sw) * $signed(mB);
    sbq.push_back(e);
    @(negedge Clk);
    chk_cnt++;
    if ({bus.Ld_B, bus.Clr_XA} !== 2'b00) $display("FAIL prio_idle: {Ld_B,Clr_XA} got %b expected 00", {bus.Ld_B, bus.Clr_XA}); else pass_cnt++;
    @(posedge Clk); #1;
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    chk_cnt++;
    if ({bus.Clr_XA, bus.Busy, bus.Ld_B} !== 3'b110) $display("FAIL prio_clr: {Clr_XA,Busy,Ld_B} got %b expected 110", {bus.Clr_XA, bus.Busy, bus.Ld_B}); else pass_cnt++;
    for (int c = 0; c < 60; c++) begin
      @(posedge Clk); #1;
      bus.ClearA_LoadB = 1'b0;
      if (sh_n == 3) bus.Run = 1'b0;
      @(negedge Clk);
      ldb_n += int'(bus.Ld_B);
      sh_n  += int'(bus.Shift_En);
      if (bus.Shift_En && !pulsed) begin
        bus.ClearA_LoadB = 1'b1;
        pulsed = 1'b1;
        #1;
        chk_cnt++;
        if (bus.Ld_B !== 1'b0) $display("FAIL prio_shift_ldb: Ld_B got %b expected 0", bus.Ld_B); else pass_cnt++;
      end
      if (bus.Done) begin
        done_seen = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (done_seen !== 1'b1) $display("FAIL prio_done: got %b expected 1", done_seen); else pass_cnt++;
    chk_cnt++;
    if (ldb_n !== 0) $display("FAIL prio_ldb_count: got %0d expected 0", ldb_n); else pass_cnt++;
    chk_cnt++;
    if (sbq.size() == 0) begin
      $display("FAIL prio_product: scoreboard empty, got %h", {mA, mB});
    end else begin
      got = sbq.pop_front();
      if ({mA, mB} !== got) $display("FAIL prio_product: got %h expected %h", {mA, mB}, got);
      else pass_cnt++;
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    chk_cnt++;
    if ({bus.Done, bus.Busy} !== 2'b00) $display("FAIL prio_back_idle: {Done,Busy} got %b expected 00", {bus.Done, bus.Busy}); else pass_cnt++;
  endtask

  task automatic test_products;
    logic [7:0]  tb_b [2];
    logic [7:0]  tb_s [2];
    logic [15:0] tb_p [2];
    logic [15:0] got;
    bit done_seen;
    tb_b[0] = 8'hFE; tb_s[0] = 8'h07; tb_p[0] = 16'hFFF2;
    tb_b[1] = 8'h80; tb_s[1] = 8'h80; tb_p[1] = 16'h4000;
    for (int k = 0; k < 2; k++) begin
      done_seen = 1'b0;
      @(posedge Clk); #1;
      sw = tb_b[k];
      bus.ClearA_LoadB = 1'b1;
      @(posedge Clk); #1;
      bus.ClearA_LoadB = 1'b0;
      sw = tb_s[k];
      bus.Run = 1'b1;
      sbq.push_back(tb_p[k]);
      for (int c = 0; c < 60; c++) begin
        @(negedge Clk);
        if (bus.Done) begin
          done_seen = 1'b1;
          break;
        end
        @(posedge Clk); #1;
      end
      chk_cnt++;
      if (done_seen !== 1'b1) $display("FAIL product%0d_done: got %b expected 1", k, done_seen); else pass_cnt++;
      chk_cnt++;
      if (sbq.size() == 0) begin
        $display("FAIL product%0d: scoreboard empty, got %h", k, {mA, mB});
      end else begin
        got = sbq.pop_front();
        if ({mA, mB} !== got) $display("FAIL product%0d: got %h expected %h", k, {mA, mB}, got);
        else pass_cnt++;
      end
      bus.Run = 1'b0;
      @(posedge Clk); #1;
      @(negedge Clk);
    end
  endtask

  initial begin
    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    test_reset();
    test_load();
    test_run_seq();
    test_hold();
    test_reset_midrun();
    test_priority();
    test_products();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
